// File: rtl/isqrt_rr_arbiter_pkg.sv
// Shared constants, tag type and one-hot helper for the isqrt round-robin arbiter.
// Optional build macro ISQRT_ARB_PRIO0_EN is consumed by isqrt_rr_arbiter.
package isqrt_arb_pkg;

    localparam int ISQRT_X_W = 32;
    localparam int ISQRT_Y_W = 16;
    localparam int N_REQ_MAX = 8;
    localparam int TAG_W     = $clog2(N_REQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

    function automatic logic [N_REQ_MAX-1:0] onehot_f(input tag_t idx);
        logic [N_REQ_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/isqrt_rr_arbiter_if.sv
// Requester-side bus of the isqrt arbiter: per-requester argument handshake and shared result.
// An argument transfers on a rising edge where req_vld[i] & req_rdy[i]; rsp_vld has no backpressure.
interface isqrt_rr_arbiter_if #(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]                               req_vld;
    logic [N_REQ-1:0][isqrt_arb_pkg::ISQRT_X_W-1:0] req_x;
    logic [N_REQ-1:0]                               req_rdy;
    logic [N_REQ-1:0]                               rsp_vld;
    logic [isqrt_arb_pkg::ISQRT_Y_W-1:0]            rsp_y;

    modport master (
        output req_vld,
        output req_x,
        input  req_rdy,
        input  rsp_vld,
        input  rsp_y
    );

    modport slave (
        input  req_vld,
        input  req_x,
        output req_rdy,
        output rsp_vld,
        output rsp_y
    );

endinterface

// File: rtl/isqrt_rr_arbiter_tag_fifo.sv
// In-order FIFO of requester tags, one entry per isqrt operation in flight.
// Pointers carry an extra MSB so full and empty are distinguishable at equal addresses.
module isqrt_tag_fifo
    import isqrt_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  tag_t                   push_tag,
    input  logic                   pop,
    output tag_t                   head_tag,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    tag_t        mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one pipelined isqrt between N_REQ requesters, results steered back by tag.
// Build macro ISQRT_ARB_PRIO0_EN gives requester 0 strict priority over the rotating others.
module isqrt_rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    isqrt_rr_arbiter_if.slave      bus,
    output logic                   isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]   isqrt_x,
    input  logic                   isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]   isqrt_y,
    output logic [$clog2(DEPTH):0] in_flight,
    output logic                   err
);

    localparam logic [TAG_W:0] N_REQ_L = (TAG_W+1)'(N_REQ);

    tag_t                   ptr;
    tag_t                   ptr_nxt;
    tag_t                   winner;
    tag_t                   head_tag;
    logic                   found;
    logic                   grant;
    logic                   full;
    logic                   empty;
    logic [2*N_REQ-1:0]     vld2;
    logic [2*N_REQ-1:0]     vld_rot;
    logic [N_REQ_MAX-1:0]   win_oh;
    logic [N_REQ_MAX-1:0]   head_oh;
    logic [TAG_W:0]         win_inc;

    // Rotating the doubled request vector puts the pointer's requester at bit 0.
    assign vld2    = {bus.req_vld, bus.req_vld};
    assign vld_rot = vld2 >> ptr;

    always_comb begin : rr_search
        logic [TAG_W:0] sum;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && vld_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (TAG_W+1)'(k);
            end
        end
        if (sum >= N_REQ_L) sum = sum - N_REQ_L;
        winner = sum[TAG_W-1:0];
`ifdef ISQRT_ARB_PRIO0_EN
        if (bus.req_vld[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    assign grant       = found && !full;
    assign win_oh      = onehot_f(winner);
    assign bus.req_rdy = grant ? win_oh[N_REQ-1:0] : '0;
    assign isqrt_x_vld = grant;

    always_comb begin
        isqrt_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_rdy[i]) isqrt_x = bus.req_x[i];
        end
    end

    assign win_inc = {1'b0, winner} + (TAG_W+1)'(1);

    always_comb begin
        ptr_nxt = ptr;
`ifdef ISQRT_ARB_PRIO0_EN
        // Priority grants to requester 0 leave the rotation among the others untouched.
        if (grant && !bus.req_vld[0]) begin
            ptr_nxt = (win_inc == N_REQ_L) ? '0 : win_inc[TAG_W-1:0];
        end
`else
        if (grant) begin
            ptr_nxt = (win_inc == N_REQ_L) ? '0 : win_inc[TAG_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr <= '0;
        else      ptr <= ptr_nxt;
    end

    isqrt_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant),
        .push_tag (winner),
        .pop      (isqrt_y_vld),
        .head_tag (head_tag),
        .full     (full),
        .empty    (empty),
        .count    (in_flight)
    );

    assign head_oh = onehot_f(head_tag);

    // A result with no tag behind it is dropped and latched as an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_vld <= '0;
            bus.rsp_y   <= '0;
            err         <= 1'b0;
        end else begin
            bus.rsp_vld <= '0;
            if (isqrt_y_vld) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    bus.rsp_vld <= head_oh[N_REQ-1:0];
                    bus.rsp_y   <= isqrt_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: an in-order isqrt stand-in with stall/inject, a per-cycle
// behavioural model with an expected-result queue, and directed plus random stimulus.
module tb_isqrt_rr_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ISQRT_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  isqrt_rr_arbiter_if #(.N_REQ(N)) bus ();

  logic          isqrt_x_vld;
  logic [31:0]   isqrt_x;
  logic          isqrt_y_vld = 1'b0;
  logic [15:0]   isqrt_y = '0;
  logic [CW-1:0] in_flight;
  logic          err;

  isqrt_rr_arbiter #(.N_REQ(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .in_flight   (in_flight),
    .err         (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    logic [31:0] r;
    logic [31:0] c;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      c = r | (32'd1 << b);
      if (64'(c) * 64'(c) <= 64'(x)) r = c;
    end
    return r[15:0];
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1 << i);
  endfunction

  // ---------------- driver tasks ----------------
  logic [31:0] drv_x [N];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [N-1:0] v, input logic [31:0] x0, x1, x2, x3);
    drv_x[0] = x0;
    drv_x[1] = x1;
    drv_x[2] = x2;
    drv_x[3] = x3;
    bus.req_vld = v;
    for (int k = 0; k < N; k++) bus.req_x[k] = drv_x[k];
  endtask

  function automatic logic [31:0] rnd_x();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 70000));
  endfunction

  // ---------------- isqrt stand-in: in order, fixed latency, stallable ----------------
  logic [31:0] eng_x_q[$];
  int          eng_due_q[$];
  int          cyc = 0;
  bit          stall = 1'b0;
  int          release_n = 0;
  bit          inject = 1'b0;
  logic [15:0] inject_y = '0;

  always @(negedge clk) begin
    if (rst && isqrt_x_vld) begin
      eng_x_q.push_back(isqrt_x);
      eng_due_q.push_back(cyc + LAT);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    isqrt_y_vld = 1'b0;
    if (!rst) begin
      eng_x_q.delete();
      eng_due_q.delete();
    end else if (inject) begin
      isqrt_y_vld = 1'b1;
      isqrt_y     = inject_y;
    end else if (eng_x_q.size() > 0 && eng_due_q[0] <= cyc && (!stall || release_n > 0)) begin
      if (stall) release_n--;
      isqrt_y_vld = 1'b1;
      isqrt_y     = isqrt_ref(eng_x_q.pop_front());
      void'(eng_due_q.pop_front());
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  // Each entry is {requester, expected root}, in issue order.
  logic [18:0]   exp_q[$];
  int            m_ptr = 0;
  logic [N-1:0]  m_rsp_vld = '0;
  logic [15:0]   m_rsp_y = '0;
  bit            m_err = 1'b0;

  function automatic int pick(input int v, input int p, input bit is_full);
    if (is_full || v == 0) return -1;
    if (PRIO0 && (v & 1) != 0) return 0;
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : compare
    int w;
    logic [18:0] e;
    if (!rst) begin
      exp_q.delete();
      m_ptr     = 0;
      m_rsp_vld = '0;
      m_rsp_y   = '0;
      m_err     = 1'b0;
      check("rst_rsp_vld", bus.rsp_vld, 0);
      check("rst_rsp_y", bus.rsp_y, 0);
      check("rst_in_flight", in_flight, 0);
      check("rst_err", err, 0);
    end else begin
      w = pick(int'(bus.req_vld), m_ptr, exp_q.size() == DEPTH);
      check("req_rdy", bus.req_rdy, (w >= 0) ? oh(w) : '0);
      check("isqrt_x_vld", isqrt_x_vld, (w >= 0) ? 1 : 0);
      check("isqrt_x", isqrt_x, (w >= 0) ? drv_x[w] : 32'd0);
      check("rsp_vld", bus.rsp_vld, m_rsp_vld);
      check("rsp_y", bus.rsp_y, m_rsp_y);
      check("in_flight", in_flight, exp_q.size());
      check("err", err, m_err);
      m_rsp_vld = '0;
      if (isqrt_y_vld) begin
        if (exp_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          e         = exp_q.pop_front();
          m_rsp_vld = oh(int'(e[18:16]));
          m_rsp_y   = e[15:0];
        end
      end
      if (w >= 0) begin
        exp_q.push_back({3'(w), isqrt_ref(drv_x[w])});
        if (!(PRIO0 && w == 0)) m_ptr = (w + 1) % N;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    stall     = 1'b0;
    release_n = 0;
    set_req('0, 0, 0, 0, 0);
    while (in_flight != 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (LAT + 2) tick();
    check(name, in_flight, 0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int grants;
    int k;
    bit found;
    int exp_g [8];
    logic [15:0] exp_y [4];
    exp_y[0] = 16'd2;
    exp_y[1] = 16'd3;
    exp_y[2] = 16'd4;
    exp_y[3] = 16'd5;

    set_req('0, 0, 0, 0, 0);
    check("ref_144", isqrt_ref(32'd144), 12);
    check("ref_25", isqrt_ref(32'd25), 5);
    check("ref_24", isqrt_ref(32'd24), 4);
    check("ref_max", isqrt_ref(32'hFFFF_FFFF), 16'hFFFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_vld", bus.rsp_vld, 0);
    check("reset_in_flight", in_flight, 0);
    check("reset_err", err, 0);
    tick();
    rst = 1'b1;

    // single request from requester 1
    tick();
    set_req(4'b0010, 0, 32'd144, 0, 0);
    @(negedge clk);
    check("single_rdy", bus.req_rdy, 4'b0010);
    check("single_x", isqrt_x, 144);
    tick();
    set_req('0, 0, 0, 0, 0);
    found = 1'b0;
    for (int n = 1; n <= 10 && !found; n++) begin
      @(negedge clk);
      if (bus.rsp_vld != 0) begin
        found = 1'b1;
        check("single_latency", n, LAT + 1);
        check("single_rsp_vld", bus.rsp_vld, 4'b0010);
        check("single_rsp_y", bus.rsp_y, 12);
      end
    end
    if (!found) check("single_timeout", 0, 1);

    // all four valid for eight cycles after reset
    do_reset();
    for (int c = 0; c < 8; c++) exp_g[c] = PRIO0 ? 0 : (c % 4);
    set_req(4'hF, 32'd4, 32'd9, 32'd16, 32'd25);
    k = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n < 8) check("rr_grant", bus.req_rdy, oh(exp_g[n]));
      if (bus.rsp_vld != 0) begin
        if (k < 8) begin
          check("rr_rsp_vld", bus.rsp_vld, oh(exp_g[k]));
          check("rr_rsp_y", bus.rsp_y, exp_y[exp_g[k]]);
        end
        k++;
      end
      tick();
      if (n == 7) set_req('0, 0, 0, 0, 0);
    end
    check("rr_rsp_count", k, 8);

    // stalled isqrt fills the tag FIFO
    stall  = 1'b1;
    grants = 0;
    for (int n = 0; n < 20; n++) begin
      set_req(4'hF, rnd_x(), rnd_x(), rnd_x(), rnd_x());
      @(negedge clk);
      if (bus.req_rdy != 0) grants++;
      tick();
    end
    check("stall_grants", grants, 16);
    @(negedge clk);
    check("stall_in_flight", in_flight, 16);
    check("stall_rdy_zero", bus.req_rdy, 0);
    tick();
    release_n = 1;
    tick();
    @(negedge clk);
    check("pop_cycle_rdy", bus.req_rdy, 0);
    tick();
    @(negedge clk);
    check("resume_rdy", (bus.req_rdy != 0) ? 1 : 0, 1);
    check("resume_in_flight", in_flight, 15);
    drain("stall_drain");

    // random traffic with bursty stalls
    for (int c = 0; c < 400; c++) begin
      tick();
      if ((c % 20) == 0) stall = ($urandom_range(0, 1) == 1);
      set_req(4'($urandom_range(0, 15)), rnd_x(), rnd_x(), rnd_x(), rnd_x());
    end
    drain("random_drain");

    // result with no tag
    tick();
    inject_y = 16'd7;
    inject   = 1'b1;
    tick();
    inject = 1'b0;
    @(negedge clk);
    check("err_not_yet", err, 0);
    tick();
    @(negedge clk);
    check("err_set", err, 1);
    check("err_rsp_vld", bus.rsp_vld, 0);
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", err, 1);

    // asynchronous reset with five operations in flight
    stall = 1'b1;
    tick();
    set_req(4'hF, 32'd100, 32'd121, 32'd169, 32'd196);
    repeat (5) tick();
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_in_flight", in_flight, 5);
    tick();
    #1;
    rst = 1'b0;
    #1;
    check("async_rsp_vld", bus.rsp_vld, 0);
    check("async_rsp_y", bus.rsp_y, 0);
    check("async_in_flight", in_flight, 0);
    check("async_err", err, 0);
    tick();
    stall = 1'b0;
    rst   = 1'b1;
    set_req(4'b1010, 0, 32'd49, 0, 32'd64);
    @(negedge clk);
    check("post_reset_grant", bus.req_rdy, 4'b0010);
    tick();
    set_req('0, 0, 0, 0, 0);
    drain("post_reset_drain");

`ifdef ISQRT_ARB_PRIO0_EN
    do_reset();
    set_req(4'hF, 32'd1, 32'd4, 32'd9, 32'd16);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("prio0_grant", bus.req_rdy, 4'b0001);
      tick();
    end
    set_req(4'hE, 32'd1, 32'd4, 32'd9, 32'd16);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("prio_rotate", bus.req_rdy, oh(1 + (n % 3)));
      tick();
    end
    drain("prio_drain");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    check("watchdog_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
